// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits are served in the same cycle; misses stall the pipeline while a line is written back and/or refilled.
module dcache_ctrl #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - 5 - IDX_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e                 state_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]   data_q [NUM_LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_sel;
    logic             hit;
    logic             store_hit;
    logic             ack;
    logic             unused_byte_bits;

    assign idx              = cpu_addr_i[5 +: IDX_W];
    assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel         = cpu_addr_i[4:2];
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    assign hit       = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
    assign store_hit = (state_q == StIdle) & hit & cpu_we_i;
    // An ack outside an outstanding request is noise and must be ignored.
    assign ack       = mem_ack_i & mem_req_o;

    assign cpu_data_o  = hit ? data_q[idx][{word_sel, 5'b0} +: 32] : '0;
    assign cpu_stall_o = (state_q != StIdle) | (cpu_req_i & ~hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            dirty_q    <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        if (cpu_we_i) dirty_q[idx] <= 1'b1;
                    end else if (cpu_req_i) begin
                        mem_req_o <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q    <= StWriteback;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= {tag_q[idx], idx, 5'b0};
                            mem_data_o <= data_q[idx];
                        end else begin
                            state_q    <= StAllocate;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {req_tag, idx, 5'b0};
                        end
                    end
                end
                StWriteback: begin
                    // mem_req_o stays high so the refill follows without a gap.
                    if (ack) begin
                        dirty_q[idx] <= 1'b0;
                        mem_we_o     <= 1'b0;
                        mem_addr_o   <= {req_tag, idx, 5'b0};
                        state_q      <= StAllocate;
                    end
                end
                StAllocate: begin
                    if (ack) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        mem_req_o    <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag/data storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (store_hit) begin
                data_q[idx][{word_sel, 5'b0} +: 32] <= cpu_data_i;
            end
            if (state_q == StAllocate && ack) begin
                data_q[idx] <= mem_data_i;
                tag_q[idx]  <= req_tag;
            end
        end
    end

endmodule
